// File: rtl/cu_pkg.sv
// Shared types and constants for the microcode sequencer.
// CU_ILLEGAL_TRAP_EN adds the LOCK state for undefined non-CB opcodes.
package cu_pkg;

    localparam int CS_WIDTH      = 65;
    localparam int UADDR_WIDTH   = 10;
    localparam int CS_ADV_LSB    = 30;
    localparam int CS_NREAD_BIT  = 32;
    localparam int CS_NWRITE_BIT = 4;

    localparam logic [UADDR_WIDTH-1:0] FETCH_UADDR       = '0;
    localparam logic [UADDR_WIDTH-1:0] NOP_ROUTINE_UADDR = UADDR_WIDTH'(4);
    localparam logic [UADDR_WIDTH-1:0] COND_TARGET_OFS   = UADDR_WIDTH'(10'h304);
    localparam logic [CS_WIDTH-1:0]    NOP_WORD          = 65'h0_0000_0001_0000_0010;

    localparam int ILLEGAL_OP_COUNT = 11;
    localparam logic [7:0] ILLEGAL_OPS [0:ILLEGAL_OP_COUNT-1] = '{
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    typedef enum logic [1:0] {
        ADV_SEQ      = 2'b00,
        ADV_DISPATCH = 2'b01,
        ADV_COND     = 2'b10,
        ADV_FETCH    = 2'b11
    } adv_t;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_RUN,
        ST_WAIT,
        ST_HALT
`ifdef CU_ILLEGAL_TRAP_EN
        , ST_LOCK
`endif
    } state_t;

    typedef struct packed {
        logic [UADDR_WIDTH-1:0] target;
        logic [CS_WIDTH-1:0]    word;
    } rom_entry_t;

    function automatic logic is_illegal_op(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < ILLEGAL_OP_COUNT; i++) begin
            if (op == ILLEGAL_OPS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Active-low strobes: a word owns the bus when either is driven low.
    function automatic logic needs_bus(input logic nread, input logic nwrite);
        return !nread || !nwrite;
    endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Sequencer-side signal bundle: decode/flag inputs and control-word outputs.
// master = surrounding CPU logic, slave = the sequencer.
interface cu_sequencer_if;

    logic [7:0]                       opcode_in;
    logic                             cb_prefix_in;
    logic                             cond_true;
    logic                             mem_ready;
    logic                             halt_req;
    logic                             wake;
    logic [cu_pkg::CS_WIDTH-1:0]      control_signals;
    logic [cu_pkg::UADDR_WIDTH-1:0]   uaddr;
    logic                             inst_boundary;
    logic                             illegal_op;

    modport master (
        output opcode_in, cb_prefix_in, cond_true, mem_ready, halt_req, wake,
        input  control_signals, uaddr, inst_boundary, illegal_op
    );

    modport slave (
        input  opcode_in, cb_prefix_in, cond_true, mem_ready, halt_req, wake,
        output control_signals, uaddr, inst_boundary, illegal_op
    );

endinterface

// File: rtl/cu_ucode_rom.sv
// Combinational microcode store: port A gives {branch target, control word},
// port B maps {cb, opcode} to the routine entry point.
module cu_ucode_rom
    import cu_pkg::*;
(
    input  logic [UADDR_WIDTH-1:0] i_a_addr,
    output rom_entry_t             o_a_entry,
    input  logic [8:0]             i_b_idx,
    output logic [UADDR_WIDTH-1:0] o_b_uaddr
);

    logic [2:0] w_slot;
    adv_t       w_adv;

    // Layout: 0 = opcode read, 1 = dispatch, 4 = NOP routine; opcode routines
    // live at 0x200 + {cb, opcode} and cycle through an 8-word slot pattern.
    always_comb begin
        w_slot = i_a_addr[2:0];
        w_adv  = ADV_SEQ;
        if (i_a_addr == UADDR_WIDTH'(1)) begin
            w_adv = ADV_DISPATCH;
        end else if (i_a_addr == NOP_ROUTINE_UADDR || w_slot == 3'd6) begin
            w_adv = ADV_FETCH;
        end else if (w_slot == 3'd4) begin
            w_adv = ADV_COND;
        end

        o_a_entry                          = '0;
        o_a_entry.word[64:55]              = i_a_addr;
        o_a_entry.word[29:20]              = ~i_a_addr;
        o_a_entry.word[3:0]                = i_a_addr[3:0];
        o_a_entry.word[CS_ADV_LSB +: 2]    = w_adv;
        o_a_entry.word[CS_NREAD_BIT]       = !(i_a_addr == FETCH_UADDR || w_slot == 3'd3);
        o_a_entry.word[CS_NWRITE_BIT]      = (w_slot != 3'd5);
        o_a_entry.target                   = i_a_addr + COND_TARGET_OFS;
    end

    always_comb begin
        o_b_uaddr = {1'b1, i_b_idx};
        if (!i_b_idx[8] && is_illegal_op(i_b_idx[7:0])) begin
            o_b_uaddr = NOP_ROUTINE_UADDR;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Microcode sequencer: micro-PC, next-address selection, memory wait and HALT.
// Build with CU_ILLEGAL_TRAP_EN to lock up on undefined non-CB opcodes.
module cu_sequencer
    import cu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    cu_sequencer_if.slave bus
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [UADDR_WIDTH-1:0] r_uaddr;
    logic [UADDR_WIDTH-1:0] w_uaddr_next;
    logic                   r_inst_boundary;
    logic                   w_inst_boundary_next;
    logic                   w_advance;
    logic                   w_bus_stall;
    rom_entry_t             w_entry;
    logic [UADDR_WIDTH-1:0] w_dispatch_uaddr;
    adv_t                   w_adv;

    cu_ucode_rom u_rom (
        .i_a_addr  (r_uaddr),
        .o_a_entry (w_entry),
        .i_b_idx   ({bus.cb_prefix_in, bus.opcode_in}),
        .o_b_uaddr (w_dispatch_uaddr)
    );

    assign w_adv       = adv_t'(w_entry.word[CS_ADV_LSB +: 2]);
    assign w_bus_stall = needs_bus(w_entry.word[CS_NREAD_BIT], w_entry.word[CS_NWRITE_BIT])
                         && !bus.mem_ready;

`ifdef CU_ILLEGAL_TRAP_EN
    logic [ILLEGAL_OP_COUNT-1:0] w_illegal_hits;
    logic                        w_trap_hit;
    logic                        r_illegal_op;

    genvar gi;
    for (gi = 0; gi < ILLEGAL_OP_COUNT; gi++) begin : g_illegal
        assign w_illegal_hits[gi] = (bus.opcode_in == ILLEGAL_OPS[gi]);
    end
    assign w_trap_hit = !bus.cb_prefix_in && (|w_illegal_hits);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_FLUSH;
            r_uaddr         <= FETCH_UADDR;
            r_inst_boundary <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_uaddr         <= w_uaddr_next;
            r_inst_boundary <= w_inst_boundary_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_uaddr_next         = r_uaddr;
        w_inst_boundary_next = 1'b0;
        w_advance            = 1'b0;

        case (r_state)
            ST_FLUSH: begin
                w_state_next = ST_RUN;
                w_uaddr_next = FETCH_UADDR;
            end
            ST_RUN: begin
                if (w_bus_stall) w_state_next = ST_WAIT;
                else             w_advance    = 1'b1;
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_next = ST_RUN;
                    w_advance    = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.wake) begin
                    w_state_next = ST_RUN;
                    w_uaddr_next = FETCH_UADDR;
                end
            end
            default: w_state_next = r_state;
        endcase

        // The word leaving RUN/WAIT decides where the micro-PC goes next.
        if (w_advance) begin
            case (w_adv)
                ADV_SEQ: w_uaddr_next = r_uaddr + UADDR_WIDTH'(1);
                ADV_DISPATCH: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    if (w_trap_hit) w_state_next = ST_LOCK;
                    else            w_uaddr_next = w_dispatch_uaddr;
`else
                    w_uaddr_next = w_dispatch_uaddr;
`endif
                end
                ADV_COND: begin
                    w_uaddr_next = bus.cond_true ? w_entry.target : r_uaddr + UADDR_WIDTH'(1);
                end
                ADV_FETCH: begin
                    w_uaddr_next         = FETCH_UADDR;
                    w_inst_boundary_next = 1'b1;
                    if (bus.halt_req && !bus.wake) w_state_next = ST_HALT;
                end
                default: w_uaddr_next = r_uaddr;
            endcase
        end
    end

    always_comb begin
        bus.control_signals = NOP_WORD;
        if (r_state == ST_RUN || r_state == ST_WAIT) begin
            bus.control_signals = w_entry.word;
        end
    end

    assign bus.uaddr         = r_uaddr;
    assign bus.inst_boundary = r_inst_boundary;

`ifdef CU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) r_illegal_op <= 1'b0;
        else     r_illegal_op <= r_illegal_op || (w_state_next == ST_LOCK);
    end
    assign bus.illegal_op = r_illegal_op;
`else
    assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed vector table, hand-written
// wait/reset sequences, then random stimulus against a behavioural model.
module tb_cu_sequencer;

    logic clk = 1'b0;
    logic rst;

    cu_sequencer_if bus();

    cu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0] ill_list [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

    localparam int M_FLUSH = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_LOCK  = 3;

    int m_mode;
    int m_upc;
    bit m_bnd;
    bit m_ill;

    typedef struct {
        bit       rst;
        bit [7:0] op;
        bit       cb, cond, ready, halt, wake;
        bit [9:0] exp_uaddr;
        bit       exp_nop, exp_bnd, exp_ill;
    } vec_t;

    vec_t vecs[$];

    // Idle word: only the two active-low bus strobes set.
    function automatic logic [64:0] nop_word();
        logic [64:0] w;
        w = '0;
        w[32] = 1'b1;
        w[4]  = 1'b1;
        return w;
    endfunction

    // Documented microprogram: 0 reads the opcode, 1 dispatches, 4 is the NOP
    // routine; elsewhere slot a%8 picks: 3 read, 4 branch, 5 write, 6 fetch.
    function automatic logic [64:0] tb_word(input int a);
        logic [64:0] w;
        logic [9:0]  av;
        int          s;
        int          kind;
        av = 10'(a);
        s  = a % 8;
        if (a == 1)                kind = 1;
        else if (a == 4 || s == 6) kind = 3;
        else if (s == 4)           kind = 2;
        else                       kind = 0;
        w         = '0;
        w[64:55]  = av;
        w[29:20]  = ~av;
        w[3:0]    = av[3:0];
        w[31:30]  = kind[1:0];
        w[32]     = !(a == 0 || s == 3);
        w[4]      = (s != 5);
        return w;
    endfunction

    function automatic bit tb_illegal(input bit [7:0] op);
        foreach (ill_list[k]) if (ill_list[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int tb_dispatch(input bit cb, input bit [7:0] op);
        if (!cb && tb_illegal(op)) return 4;
        return 512 + (cb ? 256 : 0) + int'(op);
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit [7:0] op, input bit cb, input bit cond,
                         input bit ready, input bit halt, input bit wake);
        rst              = r;
        bus.opcode_in    = op;
        bus.cb_prefix_in = cb;
        bus.cond_true    = cond;
        bus.mem_ready    = ready;
        bus.halt_req     = halt;
        bus.wake         = wake;
    endtask

    task automatic apply(input bit r, input bit [7:0] op, input bit cb, input bit cond,
                         input bit ready, input bit halt, input bit wake);
        drive(r, op, cb, cond, ready, halt, wake);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit r, input bit [7:0] op, input bit cb, input bit cond,
                       input bit ready, input bit halt, input bit wake,
                       input bit [9:0] u, input bit nop, input bit bnd, input bit ill);
        vec_t v;
        v.rst = r; v.op = op; v.cb = cb; v.cond = cond; v.ready = ready;
        v.halt = halt; v.wake = wake;
        v.exp_uaddr = u; v.exp_nop = nop; v.exp_bnd = bnd; v.exp_ill = ill;
        vecs.push_back(v);
    endtask

    // One clock of the reference: a word that owns the bus simply repeats
    // until mem_ready, otherwise its advance field picks the next address.
    task automatic model_step(input bit r, input bit [7:0] op, input bit cb, input bit cond,
                              input bit ready, input bit halt, input bit wake);
        logic [64:0] w;
        m_bnd = 1'b0;
        if (r) begin
            m_mode = M_FLUSH;
            m_upc  = 0;
            m_ill  = 1'b0;
        end else if (m_mode == M_FLUSH) begin
            m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (wake) begin
                m_mode = M_RUN;
                m_upc  = 0;
            end
        end else if (m_mode == M_RUN) begin
            w = tb_word(m_upc);
            if ((!w[32] || !w[4]) && !ready) begin
                m_mode = M_RUN;
            end else if (w[31:30] == 2'd0) begin
                m_upc = (m_upc + 1) % 1024;
            end else if (w[31:30] == 2'd1) begin
`ifdef CU_ILLEGAL_TRAP_EN
                if (!cb && tb_illegal(op)) begin
                    m_mode = M_LOCK;
                    m_ill  = 1'b1;
                end else begin
                    m_upc = tb_dispatch(cb, op);
                end
`else
                m_upc = tb_dispatch(cb, op);
`endif
            end else if (w[31:30] == 2'd2) begin
                m_upc = cond ? (m_upc + 'h304) % 1024 : (m_upc + 1) % 1024;
            end else begin
                m_upc = 0;
                m_bnd = 1'b1;
                if (halt && !wake) m_mode = M_HALT;
            end
        end
    endtask

    initial begin
        logic [64:0] exp_cs;
        bit          r, cb, cond, ready, halt, wake;
        bit   [7:0]  op;

        // rst, op, cb, cond, ready, halt, wake -> uaddr, nop, boundary, illegal
        add(1, 8'h00, 0, 0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h3E, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
        add(0, 8'h3E, 0, 0, 1, 0, 0, 10'h23E, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
        add(0, 8'h7C, 1, 0, 1, 0, 0, 10'h37C, 0, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0, 10'h280, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h281, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h282, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h283, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 10'h283, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
        add(0, 8'h1C, 0, 0, 1, 0, 0, 10'h21C, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h21D, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 10'h21D, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h21E, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 10'h000, 1, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 1, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
        add(0, 8'h1C, 0, 0, 1, 0, 0, 10'h21C, 0, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0, 10'h120, 0, 0, 0);
        add(1, 8'h00, 0, 0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
        add(0, 8'hFF, 1, 0, 1, 0, 0, 10'h3FF, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
`ifdef CU_ILLEGAL_TRAP_EN
        add(0, 8'hD3, 0, 0, 1, 0, 0, 10'h001, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1, 0, 1, 10'h001, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 1, 0, 1);
`else
        add(0, 8'hD3, 0, 0, 1, 0, 0, 10'h004, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
`endif
        add(1, 8'h00, 0, 0, 1, 0, 0, 10'h000, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);
        add(0, 8'h3E, 0, 0, 1, 0, 0, 10'h23E, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 1, 1, 10'h000, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 10'h001, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].op, vecs[i].cb, vecs[i].cond,
                  vecs[i].ready, vecs[i].halt, vecs[i].wake);
            exp_cs = vecs[i].exp_nop ? nop_word() : tb_word(int'(vecs[i].exp_uaddr));
            check($sformatf("vec%0d uaddr", i), 65'(bus.uaddr), 65'(vecs[i].exp_uaddr));
            check($sformatf("vec%0d control", i), bus.control_signals, exp_cs);
            check($sformatf("vec%0d boundary", i), 65'(bus.inst_boundary), 65'(vecs[i].exp_bnd));
            check($sformatf("vec%0d illegal", i), 65'(bus.illegal_op), 65'(vecs[i].exp_ill));
            $display("vec %0d uaddr=%h boundary=%b illegal=%b", i, bus.uaddr,
                     bus.inst_boundary, bus.illegal_op);
        end

        // Opcode read held for n cycles of mem_ready low, then advances.
        for (int n = 1; n <= 4; n++) begin
            apply(1, 8'h00, 0, 0, 1, 0, 0);
            apply(0, 8'h00, 0, 0, 1, 0, 0);
            for (int k = 0; k < n; k++) begin
                apply(0, 8'h00, 0, 0, 0, 0, 0);
                check($sformatf("wait%0d hold uaddr", n), 65'(bus.uaddr), 65'd0);
                check($sformatf("wait%0d hold word", n), bus.control_signals, tb_word(0));
            end
            apply(0, 8'h00, 0, 0, 1, 0, 0);
            check($sformatf("wait%0d release uaddr", n), 65'(bus.uaddr), 65'd1);
            $display("wait sequence n=%0d uaddr=%h", n, bus.uaddr);
        end

        // Reset while a write word is stalled must drop both strobes at once.
        apply(1, 8'h00, 0, 0, 1, 0, 0);
        apply(0, 8'h00, 0, 0, 1, 0, 0);
        apply(0, 8'h00, 0, 0, 1, 0, 0);
        apply(0, 8'h1D, 0, 0, 1, 0, 0);
        apply(0, 8'h00, 0, 0, 0, 0, 0);
        check("write stall nwrite", 65'(bus.control_signals[4]), 65'd0);
        apply(1, 8'h00, 0, 0, 0, 0, 0);
        check("abort nread", 65'(bus.control_signals[32]), 65'd1);
        check("abort nwrite", 65'(bus.control_signals[4]), 65'd1);
        $display("write abort control=%h", bus.control_signals);

        // Random stimulus against the reference model.
        for (int i = 0; i < 1500; i++) begin
            r     = (i == 0) || ($urandom_range(63) == 0);
            op    = 8'($urandom);
            cb    = ($urandom_range(3) == 0);
            cond  = 1'($urandom_range(1));
            ready = ($urandom_range(9) < 7);
            halt  = ($urandom_range(3) == 0);
            wake  = ($urandom_range(4) == 0);
            drive(r, op, cb, cond, ready, halt, wake);
            @(posedge clk);
            model_step(r, op, cb, cond, ready, halt, wake);
            #1;
            exp_cs = (m_mode == M_RUN) ? tb_word(m_upc) : nop_word();
            check($sformatf("rnd%0d uaddr", i), 65'(bus.uaddr), 65'(m_upc));
            check($sformatf("rnd%0d control", i), bus.control_signals, exp_cs);
            check($sformatf("rnd%0d boundary", i), 65'(bus.inst_boundary), 65'(m_bnd));
            check($sformatf("rnd%0d illegal", i), 65'(bus.illegal_op), 65'(m_ill));
            $display("rnd %0d rst=%b op=%h cb=%b uaddr=%h mode=%0d", i, r, op, cb,
                     bus.uaddr, m_mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Microcode sequencer that produces the 65-bit control word consumed by the datapath's control-signal field mapper.
- Holds the micro-program counter (uaddr) and reads the microcode store.
- Chooses the next uaddr from the word's advance-select field, bits [31:30]: sequential, dispatch, conditional, or fetch.
- Handles memory wait, HALT and the reset flush.
- Sits between the instruction buffer/flag logic and the datapath.

Parameters:
- CS_WIDTH, 65, control word width.
- UADDR_WIDTH, 10, micro-address width.
- FETCH_UADDR, 0, micro-address of the instruction-fetch routine.
- NOP_WORD, 65'h0_0000_0001_0000_0010, idle control word: nread (bit 32) = 1, nwrite (bit 4) = 1, all other bits 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- opcode_in  in  8  contents of the instruction buffer
- cb_prefix_in  in  1  current opcode is CB-prefixed
- cond_true  in  1  branch condition (Z/C test) evaluated for the current word
- mem_ready  in  1  bus transaction completes this cycle
- halt_req  in  1  HALT instruction executed
- wake  in  1  pending interrupt; exits HALT
- control_signals  out  65  control word to the datapath mapper
- uaddr  out  UADDR_WIDTH  current micro-address (debug)
- inst_boundary  out  1  pulses when a FETCH advance is taken
- illegal_op  out  1  sticky illegal-opcode flag (optional feature only; otherwise tied 0)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state = FLUSH, uaddr = FETCH_UADDR, control_signals = NOP_WORD, inst_boundary = 0, illegal_op = 0. rst asserted mid-instruction aborts it in the same edge; no partial bus cycle is emitted after that edge.
- States:
  - FLUSH: emits NOP_WORD for exactly 1 cycle, then goes to RUN.
  - RUN: control_signals = rom_word(uaddr), combinational from the uaddr register; zero added latency.
  - WAIT: holds uaddr and the word.
  - HALT: emits NOP_WORD.
- Memory wait: in RUN, if the word has bit 32 = 0 or bit 4 = 0 and mem_ready = 0, go to WAIT and hold. WAIT returns to RUN and advances on the cycle mem_ready = 1. mem_ready already high in the first cycle means no wait.
- Advance on bits [31:30] (in RUN, not stalled):
  - 00 SEQ: uaddr + 1, wrapping modulo 2^UADDR_WIDTH.
  - 01 DISPATCH: uaddr = dispatch_table[{cb_prefix_in, opcode_in}].
  - 10 COND: cond_true ? branch target (ROM side field) : uaddr + 1.
  - 11 FETCH: uaddr = FETCH_UADDR; inst_boundary = 1 for that cycle.
- halt_req is sampled only on a FETCH advance; if high, go to HALT.
- HALT: wake = 1 → uaddr = FETCH_UADDR, state = RUN next cycle. halt_req and wake together on a FETCH advance: wake wins, no HALT entry.
- Priority: rst > WAIT hold > HALT > advance.
- The branch target field is not forwarded on control_signals.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: DISPATCH of a non-CB opcode in {D3, DB, DD, E3, E4, EB, EC, ED, F4, FC, FD} enters LOCK. LOCK emits NOP_WORD, sets illegal_op = 1, and is exited only by rst.
- Undefined: these opcodes dispatch to their table entry (NOP routine); illegal_op is tied 0 and LOCK does not exist.

Decomposition:
- Shared package cu_pkg: advance encodings ADV_SEQ/ADV_DISPATCH/ADV_COND/ADV_FETCH, state enum, NOP_WORD, bit-index constants CS_ADV_LSB = 30, CS_NREAD_BIT = 32, CS_NWRITE_BIT = 4.
- One sub-module: cu_ucode_rom, combinational. Port A: uaddr → {branch target, 65-bit word}. Port B: 9-bit {cb, opcode} → dispatch uaddr. Initialised from a mem file.

Test Plan:
- Reset then release: cycle 0 control_signals = NOP_WORD; cycle 1 = rom_word(0), uaddr = 0.
- SEQ chain at uaddr 3FF: next uaddr = 000 (wrap); FETCH word → inst_boundary high 1 cycle, uaddr = 0.
- DISPATCH with opcode 0x3E, cb = 0 → uaddr = dispatch_table[0x03E]; with cb = 1, opcode 0x7C → dispatch_table[0x17C].
- COND word, target 0x120: cond_true = 1 → uaddr 0x120; cond_true = 0 → uaddr + 1.
- Read word (bit 32 = 0) with mem_ready low for 3 cycles → uaddr and word held 3 cycles, advance on the 4th; rst during the wait → NOP_WORD next cycle.
- halt_req on FETCH → NOP_WORD until wake; wake → uaddr = 0 next cycle. With CU_ILLEGAL_TRAP_EN, dispatch of 0xD3 → illegal_op = 1, NOP_WORD persists until rst.
